// File: rtl/store_merge_buffer_if.sv
// Store-side and line-side handshake bundle for the store merge buffer.
// slave is the buffer's view; master is the view of the CPU/cache environment driving it.
interface store_merge_buffer_if #(
   parameter int LINE_BYTES = 16,
   parameter int WORD_BYTES = 2,
   parameter int ADDR_W     = 16
);
   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int TAG_W = ADDR_W - OFF_W;

   logic                    store_valid;
   logic                    store_ready;
   logic [ADDR_W-1:0]       store_addr;
   logic [8*WORD_BYTES-1:0] store_data;
   logic [WORD_BYTES-1:0]   store_be;
   logic                    flush_req;
   logic                    line_valid;
   logic                    line_ready;
   logic [TAG_W-1:0]        line_addr;
   logic [8*LINE_BYTES-1:0] line_data;
   logic [LINE_BYTES-1:0]   line_mask;
   logic                    empty;

   modport slave (
      input  store_valid, store_addr, store_data, store_be, flush_req, line_ready,
      output store_ready, line_valid, line_addr, line_data, line_mask, empty
   );

   modport master (
      output store_valid, store_addr, store_data, store_be, flush_req, line_ready,
      input  store_ready, line_valid, line_addr, line_data, line_mask, empty
   );
endinterface

// File: rtl/store_merge_buffer.sv
// Write-combining buffer: merges word stores into one line with a byte dirty mask; bytes land next cycle,
// line_valid rises one cycle after miss/flush/full; stores stall on tag miss and while the line drains.
module store_merge_buffer #(
   parameter int LINE_BYTES = 16,
   parameter int WORD_BYTES = 2,
   parameter int ADDR_W     = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   store_merge_buffer_if.slave bus
);
   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int TAG_W = ADDR_W - OFF_W;

   typedef enum logic [1:0] {IDLE, MERGE, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [TAG_W-1:0]        tag_q, tag_d;
   logic [8*LINE_BYTES-1:0] data_q, data_d, merged_data;
   logic [LINE_BYTES-1:0]   mask_q, mask_d, merged_mask;
   logic [TAG_W-1:0]        store_tag;
   logic [OFF_W-1:0]        word_base;
   logic                    tag_hit;
   logic                    store_rdy;
   logic                    store_acc;

   assign store_tag = bus.store_addr[ADDR_W-1:OFF_W];
   assign word_base = bus.store_addr[OFF_W-1:0] & ~OFF_W'(WORD_BYTES - 1);
   assign tag_hit   = (store_tag == tag_q);
   assign store_acc = bus.store_valid && store_rdy;

   // Ready depends only on state and the store itself, never on line_ready.
   always_comb begin
      store_rdy = 1'b0;
      case (state_q)
         IDLE:    store_rdy = 1'b1;
         MERGE:   store_rdy = !bus.store_valid || tag_hit;
         default: store_rdy = 1'b0;
      endcase
   end

   // In IDLE the buffer is already cleared, so the same merge serves both load and accumulate.
   always_comb begin
      merged_data = data_q;
      merged_mask = mask_q;
      for (int w = 0; w < WORD_BYTES; w++) begin
         for (int j = 0; j < LINE_BYTES; j++) begin
            if (bus.store_be[w] && (OFF_W'(j) == word_base + OFF_W'(w))) begin
               merged_data[8*j +: 8] = bus.store_data[8*w +: 8];
               merged_mask[j]        = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      data_d  = data_q;
      mask_d  = mask_q;
      case (state_q)
         IDLE: begin
            if (store_acc && (bus.store_be != '0)) begin
               tag_d   = store_tag;
               data_d  = merged_data;
               mask_d  = merged_mask;
               state_d = MERGE;
            end
         end
         MERGE: begin
            if (store_acc) begin
               data_d = merged_data;
               mask_d = merged_mask;
            end
            if (bus.flush_req || (bus.store_valid && !tag_hit) || (&mask_d)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.line_ready) begin
               tag_d   = '0;
               data_d  = '0;
               mask_d  = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tag_q   <= '0;
         data_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
      end
   end

   assign bus.store_ready = store_rdy;
   assign bus.line_valid  = (state_q == DRAIN);
   assign bus.line_addr   = tag_q;
   assign bus.line_data   = data_q;
   assign bus.line_mask   = mask_q;
   assign bus.empty       = (state_q == IDLE);
endmodule

// File: tb/tb_store_merge_buffer.sv
// Bench for store_merge_buffer: directed scenarios plus random stores, with drained lines
// scoreboarded against a byte-array model of the write-combining rules.
module tb_store_merge_buffer;
   logic clk;
   logic rst_n;

   store_merge_buffer_if #(.LINE_BYTES(16), .WORD_BYTES(2), .ADDR_W(16)) bus ();

   store_merge_buffer #(.LINE_BYTES(16), .WORD_BYTES(2), .ADDR_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0]  tag;
      logic [127:0] data;
      logic [15:0]  mask;
   } line_t;

   line_t      exp_q[$];
   logic [7:0] mbytes[16];
   logic [15:0] mdirty;
   logic [11:0] mtag;
   bit         mheld;

   int total;
   int bad;
   bit rdy_force;
   bit rdy_val;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic timeout_fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting on DUT", nm);
   endtask

   // Reference model: one held line as a byte array with a dirty bit per byte.
   task automatic model_push();
      line_t e;
      e.tag  = mtag;
      e.mask = mdirty;
      e.data = '0;
      for (int i = 0; i < 16; i++)
         if (mdirty[i]) e.data[8*i +: 8] = mbytes[i];
      exp_q.push_back(e);
      mheld  = 1'b0;
      mdirty = '0;
   endtask

   task automatic model_store(input logic [15:0] a, input logic [15:0] d,
                              input logic [1:0] be, input bit fl);
      logic [11:0] tg;
      int          base;
      bit          hit_flush;
      tg        = a[15:4];
      base      = int'(a[3:1]) * 2;
      hit_flush = fl && mheld && (tg == mtag);
      if (mheld && tg != mtag) model_push();
      if (be != 2'b00) begin
         if (!mheld) begin
            mheld = 1'b1;
            mtag  = tg;
         end
         for (int i = 0; i < 2; i++)
            if (be[i]) begin
               mbytes[base+i] = d[8*i +: 8];
               mdirty[base+i] = 1'b1;
            end
      end
      if (mheld && (hit_flush || mdirty == 16'hFFFF)) model_push();
   endtask

   task automatic do_store(input logic [15:0] a, input logic [15:0] d,
                           input logic [1:0] be, input bit fl);
      int n;
      model_store(a, d, be, fl);
      bus.store_valid = 1'b1;
      bus.store_addr  = a;
      bus.store_data  = d;
      bus.store_be    = be;
      bus.flush_req   = fl;
      n = 0;
      @(negedge clk);
      while (!bus.store_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.store_ready) timeout_fail("store_accept");
      @(posedge clk);
      #1;
      bus.store_valid = 1'b0;
      bus.flush_req   = 1'b0;
   endtask

   task automatic do_flush();
      if (mheld) model_push();
      bus.flush_req = 1'b1;
      @(posedge clk);
      #1;
      bus.flush_req = 1'b0;
   endtask

   task automatic wait_empty();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(posedge clk);
         #3;
         if (bus.empty && exp_q.size() == 0) ok = 1'b1;
      end
      if (!ok) timeout_fail("drain_to_empty");
      @(posedge clk);
      #1;
   endtask

   task automatic chk_line(input logic [11:0] ea, input logic [127:0] ed, input logic [15:0] em);
      chk("line_valid_up", bus.line_valid, 1'b1);
      chk("line_addr", bus.line_addr, ea);
      chk("line_data", bus.line_data, ed);
      chk("line_mask", bus.line_mask, em);
   endtask

   task automatic release_line();
      rdy_val = 1'b1;
      wait_empty();
      rdy_val = 1'b0;
   endtask

   task automatic flush_check(input logic [11:0] ea, input logic [127:0] ed, input logic [15:0] em);
      if (mheld) model_push();
      bus.flush_req = 1'b1;
      @(negedge clk);
      chk("flush_latency_low", bus.line_valid, 1'b0);
      @(posedge clk);
      #1;
      bus.flush_req = 1'b0;
      @(negedge clk);
      chk_line(ea, ed, em);
      release_line();
   endtask

   // line_ready driver: forced level in directed parts, random in the soak.
   initial begin
      bus.line_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         bus.line_ready = rdy_force ? rdy_val : 1'($urandom_range(0, 1));
      end
   end

   // Monitor: every line handshake pops one expected line.
   initial begin
      line_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.line_valid && bus.line_ready) begin
            if (exp_q.size() == 0) begin
               timeout_fail("unexpected_line");
            end else begin
               e = exp_q.pop_front();
               chk("sb_addr", bus.line_addr, e.tag);
               chk("sb_data", bus.line_data, e.data);
               chk("sb_mask", bus.line_mask, e.mask);
            end
         end
      end
   end

   initial begin
      logic [127:0] full_exp;
      logic [15:0]  d;
      logic [11:0]  tg;
      int           n;
      total = 0;
      bad   = 0;
      mheld = 1'b0;
      mdirty = '0;
      mtag  = '0;
      for (int i = 0; i < 16; i++) mbytes[i] = 8'h00;
      rdy_force = 1'b1;
      rdy_val   = 1'b0;
      bus.store_valid = 1'b0;
      bus.store_addr  = '0;
      bus.store_data  = '0;
      bus.store_be    = '0;
      bus.flush_req   = 1'b0;
      rst_n = 1'b0;

      #3;
      chk("rst_line_valid", bus.line_valid, 1'b0);
      chk("rst_empty", bus.empty, 1'b1);
      chk("rst_line_data", bus.line_data, '0);
      chk("rst_line_mask", bus.line_mask, '0);
      chk("rst_line_addr", bus.line_addr, '0);
      #20;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_store_ready", bus.store_ready, 1'b1);
      @(posedge clk);
      #1;

      // Partial merge and flush
      do_store(16'h0104, 16'hBEEF, 2'b11, 1'b0);
      do_store(16'h0106, 16'h0012, 2'b01, 1'b0);
      flush_check(12'h010, 128'h0000_0000_0000_0000_0012_BEEF_0000_0000, 16'h0070);

      // Overwrite ordering, low address bit ignored
      do_store(16'h0100, 16'h1111, 2'b11, 1'b0);
      do_store(16'h0101, 16'h2233, 2'b10, 1'b0);
      flush_check(12'h010, 128'h2211, 16'h0003);

      // Tag miss held under backpressure
      do_store(16'h0100, 16'hAAAA, 2'b11, 1'b0);
      model_store(16'h0200, 16'h5555, 2'b11, 1'b0);
      bus.store_valid = 1'b1;
      bus.store_addr  = 16'h0200;
      bus.store_data  = 16'h5555;
      bus.store_be    = 2'b11;
      @(negedge clk);
      chk("miss_ready_low", bus.store_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("miss_ready_low", bus.store_ready, 1'b0);
         chk_line(12'h010, 128'hAAAA, 16'h0003);
      end
      @(posedge clk);
      #1;
      rdy_val = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.store_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("miss_accept_cycles", n, 1);
      @(posedge clk);
      #1;
      bus.store_valid = 1'b0;
      rdy_val = 1'b0;
      @(negedge clk);
      chk("miss_not_empty", bus.empty, 1'b0);
      chk("miss_new_tag", bus.line_addr, 12'h020);
      @(posedge clk);
      #1;
      flush_check(12'h020, 128'h5555, 16'h0003);

      // Full-line auto drain
      full_exp = '0;
      for (int k = 0; k < 8; k++) begin
         d = 16'($urandom);
         full_exp[16*k +: 16] = d;
         if (k == 7) begin
            @(negedge clk);
            chk("full_not_early", bus.line_valid, 1'b0);
            @(posedge clk);
            #1;
         end
         do_store(16'h0300 + 16'(2*k), d, 2'b11, 1'b0);
      end
      @(negedge clk);
      chk_line(12'h030, full_exp, 16'hFFFF);
      release_line();

      // Same-tag store together with flush
      do_store(16'h0100, 16'h1234, 2'b11, 1'b0);
      do_store(16'h0108, 16'hCAFE, 2'b11, 1'b1);
      @(negedge clk);
      chk_line(12'h010, 128'h0000_0000_0000_CAFE_0000_0000_0000_1234, 16'h0303);
      release_line();

      // Reset while draining discards the line
      do_store(16'h0300, 16'h7777, 2'b11, 1'b0);
      do_flush();
      @(negedge clk);
      chk("pre_rst_valid", bus.line_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", bus.line_valid, 1'b0);
      chk("async_rst_empty", bus.empty, 1'b1);
      chk("async_rst_mask", bus.line_mask, '0);
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_store(16'h0400, 16'h9999, 2'b11, 1'b0);
      flush_check(12'h040, 128'h9999, 16'h0003);

      // Random soak with random line_ready
      rdy_force = 1'b0;
      for (int op = 0; op < 400; op++) begin
         case ($urandom_range(0, 2))
            0: tg = 12'h010;
            1: tg = 12'h011;
            default: tg = 12'h020;
         endcase
         n = $urandom_range(0, 9);
         if (n == 7) do_flush();
         else do_store({tg, 4'($urandom)}, 16'($urandom), 2'($urandom), n > 7);
      end
      do_flush();
      wait_empty();
      chk("soak_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/store_merge_buffer.md
Name: store_merge_buffer

Overview:
- Write-combining buffer between the CPU store path and the cache/memory line write port.
- Accepts word-sized stores with byte enables. Merges stores to the same line into one line-wide buffer and tracks a per-byte dirty mask.
- Emits the merged line with its mask when the line changes, the line becomes fully dirty, or a flush is requested.
- Generalises the combinational single-store line merge: parametrised line/word/address widths, multi-store accumulation, and valid/ready handshakes on both sides.

Parameters:
- LINE_BYTES, 16: bytes per line. Power of two, ≥ WORD_BYTES.
- WORD_BYTES, 2: bytes per store word. Power of two.
- ADDR_W, 16: byte address width.
- Derived: OFF_W = log2(LINE_BYTES), WOFF_W = log2(WORD_BYTES), TAG_W = ADDR_W - OFF_W.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- store_valid  in  1  store request.
- store_ready  out  1  store accepted when store_valid && store_ready.
- store_addr  in  ADDR_W  byte address; low WOFF_W bits ignored (word-aligned).
- store_data  in  8*WORD_BYTES  store word; byte i of the word goes to line byte (word offset*WORD_BYTES + i).
- store_be  in  WORD_BYTES  per-byte write enable.
- flush_req  in  1  level request to drain the held line.
- line_valid  out  1  merged line presented.
- line_ready  in  1  line consumed when line_valid && line_ready.
- line_addr  out  TAG_W  line tag (store_addr[ADDR_W-1:OFF_W]).
- line_data  out  8*LINE_BYTES  merged line; non-dirty bytes are 0.
- line_mask  out  LINE_BYTES  dirty byte mask.
- empty  out  1  no line held (state IDLE).

Behaviour:
- States: IDLE (no line), MERGE (line held, accepting), DRAIN (line presented).
- Reset (async, rst_n low): state IDLE; buffer data/mask/tag cleared.
  - Outputs during and after reset: line_valid=0, line_data=0, line_mask=0, line_addr=0, empty=1, store_ready=1 once rst_n is high.
  - Reset mid-DRAIN discards the line with no handshake.
- store_ready is combinational from state and inputs:
  - 1 in IDLE.
  - 1 in MERGE when the store tag equals the held tag, or when store_valid=0.
  - 0 in MERGE on a tag miss.
  - 0 in DRAIN.
- IDLE:
  - Accepted store with store_be≠0: load tag and enabled bytes, set mask bits; go to MERGE.
  - Store with store_be=0: accepted and dropped; stay IDLE.
  - flush_req in IDLE: ignored.
- MERGE:
  - Same-tag store: write enabled bytes (new data overwrites older bytes), OR in mask bits.
  - Tag miss: store stalls; go to DRAIN next cycle.
  - flush_req: go to DRAIN. A same-tag store in the same cycle is merged first and included in the drained line.
  - Auto-drain: if the post-merge mask is all ones, go to DRAIN.
- DRAIN:
  - line_valid=1; line_addr, line_data and line_mask are driven from registers and held stable until the handshake.
  - On line_valid && line_ready: clear the buffer, go to IDLE next cycle.
  - A stalled store is accepted in IDLE on the following cycle. Minimum miss penalty is 2 cycles plus the line_ready wait.
- Latency:
  - A merged byte is visible in the buffer the cycle after acceptance.
  - line_valid rises the cycle after the triggering event (miss, flush, or full mask).
- No combinational path from line_ready to store_ready.
- empty=1 exactly when state is IDLE.

Test Plan (defaults LINE_BYTES=16, WORD_BYTES=2, ADDR_W=16):
- Partial merge and flush:
  - Stimulus: store 0x0104 data 0xBEEF be 11, then 0x0106 data 0x0012 be 01, then flush_req.
  - Response: line_valid next cycle; line_addr 0x010; mask 0x0070; byte4=EF, byte5=BE, byte6=12; all other bytes 00.
- Overwrite ordering:
  - Stimulus: store 0x0100 0x1111 be 11, then 0x0101 0x2233 be 10, then flush.
  - Response: byte0=11, byte1=22; mask 0x0003.
- Tag miss with backpressure:
  - Stimulus: line held at tag 0x010; store 0x0200 arrives; hold line_ready=0 for 3 cycles.
  - Response: store_ready=0 throughout; line outputs stable; after the handshake, the store is accepted one cycle later; empty=0; tag 0x020.
- Full-line auto-drain:
  - Stimulus: 8 stores with be 11 to 0x0300..0x030E, no flush.
  - Response: line_valid the cycle after the 8th store; mask 0xFFFF; data equals the stored words.
- Simultaneous same-tag store and flush:
  - Stimulus: store 0x0108 0xCAFE in the same cycle as flush_req, with line tag 0x010 held.
  - Response: store accepted; drained line includes CAFE at bytes 8–9.
- Reset mid-DRAIN:
  - Stimulus: drop rst_n while line_valid=1.
  - Response: line_valid=0 and empty=1 immediately (asynchronously); after release, a store to 0x0400 is accepted cleanly with mask 0x0003.
